ras_commit_repair: RTL and testbench

Architectural (commit-side) return address stack plus repair sequencer. It sits at the retire end of the pipeline and pairs with the speculative fetch-side RAS. Calls and returns are applied only as they retire. On a pipeline flush it streams the committed stack, oldest entry first, to the fetch RAS over a valid/ready handshake so the speculative stack can be rebuilt.

---
 rtl/ras_pkg.sv | 16 +
 rtl/ras_arch_stack.sv | 90 +++++++++
 rtl/ras_commit_repair.sv | 124 ++++++++++++
 tb/tb_ras_commit_repair.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared definitions for the commit-side return address stack.
//   RAS_DEPTH   : system RAS depth (fetch and commit stacks must agree)
//   RAS_IDX_W   : slot index width for RAS_DEPTH
//   ras_state_e : repair sequencer states
package ras_pkg;

    localparam int RAS_DEPTH = 8;
    localparam int RAS_IDX_W = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {
        RAS_IDLE   = 2'd0,
        RAS_STREAM = 2'd1,
        RAS_DONE   = 2'd2
    } ras_state_e;

endpackage

// File: rtl/ras_arch_stack.sv
// Committed return address stack: circular buffer with a registered base
// (oldest slot) and count. Applies retired pops and pushes, handles overflow,
// and offers a read port addressed by logical index (0 = bottom).
// Optional feature macro: RAS_OVERFLOW_WRAP_EN (push when full overwrites the
// oldest entry instead of being dropped).
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   push, push_npc   : retiring call and its return address
//   pop              : retiring return
//   rd_idx / rd_npc  : logical-index read port
//   top_npc, empty   : committed top entry (0 when empty), empty flag
//   base             : current oldest slot
//   base_nxt/count_nxt : state after this cycle's commits (used for snapshots)
module ras_arch_stack
    import ras_pkg::*;
#(
    parameter int N_ENTRY = RAS_DEPTH,
    parameter int IDX_W   = $clog2(N_ENTRY)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [63:0]      push_npc,
    input  logic             pop,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [63:0]      rd_npc,
    output logic [63:0]      top_npc,
    output logic             empty,
    output logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] base_nxt,
    output logic [IDX_W:0]   count_nxt
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(N_ENTRY);
    localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

    logic [63:0]      mem [N_ENTRY];
    logic [IDX_W-1:0] base_q;
    logic [IDX_W:0]   count_q;
    logic [IDX_W:0]   cnt_pop;
    logic             do_write;
    logic [IDX_W-1:0] wr_slot;
    logic [IDX_W-1:0] top_slot;

    // Pop is applied before push, so call+ret together replaces the top.
    always_comb begin
        cnt_pop   = (pop && count_q != '0) ? count_q - ONE : count_q;
        base_nxt  = base_q;
        count_nxt = cnt_pop;
        do_write  = 1'b0;
        wr_slot   = base_q + cnt_pop[IDX_W-1:0];
        if (push) begin
            if (cnt_pop < FULL) begin
                do_write  = 1'b1;
                count_nxt = cnt_pop + ONE;
            end
`ifdef RAS_OVERFLOW_WRAP_EN
            else begin
                // Full: overwrite the oldest slot; it becomes the new top.
                do_write = 1'b1;
                wr_slot  = base_q;
                base_nxt = base_q + IDX_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_q  <= '0;
            count_q <= '0;
        end else begin
            base_q  <= base_nxt;
            count_q <= count_nxt;
        end
    end

    // Storage needs no reset: every read that reaches an output is gated.
    always_ff @(posedge clock) begin
        if (do_write) mem[wr_slot] <= push_npc;
    end

    // Low IDX_W bits of a full count are 0, so the -1 still lands on the top.
    assign top_slot = base_q + count_q[IDX_W-1:0] - IDX_W'(1);
    assign empty    = (count_q == '0);
    assign top_npc  = empty ? 64'd0 : mem[top_slot];
    assign rd_npc   = mem[base_q + rd_idx];
    assign base     = base_q;

endmodule

// File: rtl/ras_commit_repair.sv
// Commit-side RAS plus repair sequencer. Retired calls/returns update the
// architectural stack; a flush snapshots it and streams it oldest-first to the
// fetch RAS over valid/ready, then pulses repair_done.
// Optional feature macro: RAS_OVERFLOW_WRAP_EN (see ras_arch_stack).
// Ports:
//   clock, reset                       : clock, synchronous active-high reset
//   call_commit, call_commit_NPC       : retiring call and its return address
//   ret_commit                         : retiring return
//   flush                              : recovery trigger
//   repair_ready                       : fetch RAS accepts a beat
//   repair_valid/idx/NPC/last          : repair beat
//   repair_count                       : entries in the latest snapshot
//   repair_done                        : one-cycle completion pulse
//   repair_busy                        : sequencer active; no commits allowed
//   arch_empty, arch_top_NPC           : committed stack status
// All outputs come from registers; no input-to-output combinational path.
module ras_commit_repair
    import ras_pkg::*;
#(
    parameter int N_ENTRY = RAS_DEPTH,
    parameter int IDX_W   = $clog2(N_ENTRY)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             call_commit,
    input  logic [63:0]      call_commit_NPC,
    input  logic             ret_commit,
    input  logic             flush,
    input  logic             repair_ready,
    output logic             repair_valid,
    output logic [IDX_W-1:0] repair_idx,
    output logic [63:0]      repair_NPC,
    output logic             repair_last,
    output logic [IDX_W:0]   repair_count,
    output logic             repair_done,
    output logic             repair_busy,
    output logic             arch_empty,
    output logic [63:0]      arch_top_NPC
);

    ras_state_e       state_q, state_d;
    logic [IDX_W-1:0] snap_base_q, snap_base_d;
    logic [IDX_W:0]   snap_count_q, snap_count_d;
    logic [IDX_W-1:0] k_q, k_d;

    logic [IDX_W-1:0] cur_base, base_nxt, rd_idx;
    logic [IDX_W:0]   count_nxt;
    logic [63:0]      rd_npc;
    logic             beat_last;

    ras_arch_stack #(.N_ENTRY(N_ENTRY), .IDX_W(IDX_W)) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (call_commit),
        .push_npc  (call_commit_NPC),
        .pop       (ret_commit),
        .rd_idx    (rd_idx),
        .rd_npc    (rd_npc),
        .top_npc   (arch_top_NPC),
        .empty     (arch_empty),
        .base      (cur_base),
        .base_nxt  (base_nxt),
        .count_nxt (count_nxt)
    );

    // Beat k is snapshot entry k; rebase it onto the live stack's base so a
    // snapshot stays addressable even if the base moved after it was taken.
    assign rd_idx    = k_q + snap_base_q - cur_base;
    assign beat_last = ({1'b0, k_q} == snap_count_q - (IDX_W+1)'(1));

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        snap_base_d  = snap_base_q;
        snap_count_d = snap_count_q;
        case (state_q)
            RAS_STREAM: begin
                if (repair_ready) begin
                    if (beat_last) state_d = RAS_DONE;
                    else           k_d     = k_q + IDX_W'(1);
                end
            end
            RAS_DONE: begin
                state_d = RAS_IDLE;
                k_d     = '0;
            end
            default: ;
        endcase
        // Flush wins in every state; the snapshot includes this cycle's commit.
        if (flush) begin
            snap_base_d  = base_nxt;
            snap_count_d = count_nxt;
            k_d          = '0;
            state_d      = (count_nxt != '0) ? RAS_STREAM : RAS_DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RAS_IDLE;
            k_q          <= '0;
            snap_base_q  <= '0;
            snap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            snap_base_q  <= snap_base_d;
            snap_count_q <= snap_count_d;
        end
    end

    assign repair_valid = (state_q == RAS_STREAM);
    assign repair_idx   = repair_valid ? k_q : '0;
    assign repair_NPC   = repair_valid ? rd_npc : 64'd0;
    assign repair_last  = repair_valid && beat_last;
    assign repair_done  = (state_q == RAS_DONE);
    assign repair_busy  = (state_q != RAS_IDLE);
    assign repair_count = snap_count_q;

    // The ROB must hold off retirement of calls/returns during a repair.
    a_no_commit_busy: assert property (@(posedge clock) disable iff (reset)
        !(repair_busy && (call_commit || ret_commit)));

endmodule

// File: tb/tb_ras_commit_repair.sv
module tb_ras_commit_repair;
    localparam int N = 8;
    localparam int IW = $clog2(N);

    logic          clock = 1'b0;
    logic          reset, call_commit, ret_commit, flush, repair_ready;
    logic [63:0]   call_commit_NPC;
    logic          repair_valid, repair_last, repair_done, repair_busy, arch_empty;
    logic [IW-1:0] repair_idx;
    logic [IW:0]   repair_count;
    logic [63:0]   repair_NPC, arch_top_NPC;

    always #5 clock = ~clock;

    ras_commit_repair dut (
        .clock(clock), .reset(reset),
        .call_commit(call_commit), .call_commit_NPC(call_commit_NPC),
        .ret_commit(ret_commit), .flush(flush), .repair_ready(repair_ready),
        .repair_valid(repair_valid), .repair_idx(repair_idx), .repair_NPC(repair_NPC),
        .repair_last(repair_last), .repair_count(repair_count), .repair_done(repair_done),
        .repair_busy(repair_busy), .arch_empty(arch_empty), .arch_top_NPC(arch_top_NPC)
    );

    // Behavioural model: the stack as a queue (front = oldest), the snapshot as
    // a copy, and the repair phase as 0 idle / 1 streaming / 2 done.
    logic [63:0] stk[$];
    logic [63:0] snap[$];
    int          mode, k, rcount;
    int          n_cmp = 0, n_bad = 0;

    function automatic void model_step(input logic c, input logic [63:0] npc,
                                       input logic r, input logic f,
                                       input logic rdy, input logic rs);
        if (rs) begin
            stk.delete(); snap.delete(); mode = 0; k = 0; rcount = 0;
            return;
        end
        if (r && stk.size() > 0) void'(stk.pop_back());
        if (c) begin
            if (stk.size() < N) stk.push_back(npc);
`ifdef RAS_OVERFLOW_WRAP_EN
            else begin void'(stk.pop_front()); stk.push_back(npc); end
`endif
        end
        case (mode)
            1: if (rdy) begin
                   if (k == snap.size() - 1) mode = 2;
                   else k++;
               end
            2: begin mode = 0; k = 0; end
            default: ;
        endcase
        if (f) begin
            snap = stk; k = 0; rcount = stk.size();
            mode = (stk.size() > 0) ? 1 : 2;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic mv;
        mv = (mode == 1);
        chk("repair_valid", repair_valid, mv);
        chk("repair_idx",   repair_idx,   mv ? k : 0);
        chk("repair_NPC",   repair_NPC,   mv ? snap[k] : 64'd0);
        chk("repair_last",  repair_last,  mv && (k == snap.size() - 1));
        chk("repair_done",  repair_done,  mode == 2);
        chk("repair_busy",  repair_busy,  mode != 0);
        chk("repair_count", repair_count, rcount);
        chk("arch_empty",   arch_empty,   stk.size() == 0);
        chk("arch_top_NPC", arch_top_NPC, (stk.size() == 0) ? 64'd0 : stk[$]);
    endtask

    // One clock: drive at negedge, advance the model, compare at next negedge.
    task automatic cyc(input logic c, input logic [63:0] npc, input logic r,
                       input logic f, input logic rdy, input logic rs);
        call_commit = c; call_commit_NPC = npc; ret_commit = r;
        flush = f; repair_ready = rdy; reset = rs;
        model_step(c, npc, r, f, rdy, rs);
        @(negedge clock);
        compare_all();
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
    endtask

    task automatic push(input logic [63:0] v);
        cyc(1, v, 0, 0, 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && mode != 0; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("drain_idle", repair_busy, 1'b0);
    endtask

    initial begin
        reset = 1; call_commit = 0; ret_commit = 0; flush = 0;
        repair_ready = 1; call_commit_NPC = 0;
        mode = 0; k = 0; rcount = 0;
        @(negedge clock);

        // Reset values
        do_reset();
        chk("rst_valid", repair_valid, 0);
        chk("rst_empty", arch_empty, 1);
        chk("rst_count", repair_count, 0);
        chk("rst_top",   arch_top_NPC, 0);

        // Three calls then flush: beats in order, then done with count 3
        push(64'h100); push(64'h200); push(64'h300);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t1_b0_idx", repair_idx, 0);
        chk("t1_b0_npc", repair_NPC, 64'h100);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t1_b1_npc", repair_NPC, 64'h200);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t1_b2_npc",  repair_NPC, 64'h300);
        chk("t1_b2_last", repair_last, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t1_done",  repair_done, 1);
        chk("t1_count", repair_count, 3);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t1_idle", repair_busy, 0);

        // Underflow, then flush of an empty stack
        do_reset();
        push(64'h100); push(64'h200);
        cyc(0, 0, 1, 0, 1, 0); cyc(0, 0, 1, 0, 1, 0); cyc(0, 0, 1, 0, 1, 0);
        chk("t2_empty", arch_empty, 1);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t2_done",  repair_done, 1);
        chk("t2_valid", repair_valid, 0);
        chk("t2_count", repair_count, 0);
        drain();

        // Simultaneous call+ret replaces the top
        do_reset();
        push(64'h100);
        cyc(1, 64'h500, 1, 0, 1, 0);
        chk("t3_top", arch_top_NPC, 64'h500);
        cyc(0, 0, 0, 1, 1, 0);
        chk("t3_count", repair_count, 1);
        drain();

        // Overflow: nine pushes on an eight-deep stack
        do_reset();
        for (int i = 1; i <= 9; i++) push(64'(i * 16));
        cyc(0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
`ifdef RAS_OVERFLOW_WRAP_EN
            chk("t4_npc", repair_NPC, 64'((i + 2) * 16));
`else
            chk("t4_npc", repair_NPC, 64'((i + 1) * 16));
`endif
            chk("t4_idx", repair_idx, i);
            cyc(0, 0, 0, 0, 1, 0);
        end
        chk("t4_done", repair_done, 1);

        // Backpressure: hold ready low, then toggle
        do_reset();
        for (int i = 1; i <= 4; i++) push(64'(i * 64'h1000));
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("t5_hold_idx", repair_idx, 0);
            chk("t5_hold_npc", repair_NPC, 64'h1000);
        end
        for (int i = 0; i < 20 && mode != 0; i++) cyc(0, 0, 0, 0, 1'(i % 2), 0);
        chk("t5_idle", repair_busy, 0);

        // Flush restart during beat 2
        do_reset();
        for (int i = 1; i <= 4; i++) push(64'(i * 64'h1000));
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t6_at_b2", repair_idx, 2);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t6_restart_idx", repair_idx, 0);
        chk("t6_restart_npc", repair_NPC, 64'h1000);
        drain();

        // Reset during beat 1
        for (int i = 1; i <= 4; i++) push(64'(i * 64'h1000));
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t7_at_b1", repair_idx, 1);
        cyc(0, 0, 0, 0, 1, 1);
        chk("t7_valid", repair_valid, 0);
        chk("t7_done",  repair_done, 0);
        chk("t7_busy",  repair_busy, 0);
        chk("t7_count", repair_count, 0);
        chk("t7_empty", arch_empty, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t7_no_done", repair_done, 0);

        // Randomized traffic; commits only while the sequencer is idle
        for (int i = 0; i < 3000; i++) begin
            logic c, r, f, rdy, rs;
            c   = (mode == 0) && ($urandom % 10 < 4);
            r   = (mode == 0) && ($urandom % 10 < 3);
            f   = ($urandom % 25 == 0);
            rdy = ($urandom % 10 < 7);
            rs  = ($urandom % 400 == 0);
            cyc(c, {$urandom, $urandom}, r, f, rdy, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
